sample_uart_framer: RTL and testbench

//  Transmit-direction companion to the UART RX path. Buffers filtered ECG samples from the FIR

---
 rtl/filter_pkg.sv | 19 +
 rtl/sync_fifo.sv | 53 +++++
 rtl/sample_uart_framer.sv | 122 ++++++++++++
 tb/tb_sample_uart_framer.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/filter_pkg.sv
// Shared types and constants for the sample framer.
package filter_pkg;

   localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      START,
      WAIT_HI,
      WAIT_LO
   } framer_state_t;

   // Number of whole bytes in a sample of the given bit width.
   function automatic int nbytes(input int width);
      return width / 8;
   endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with a registered occupancy count.
module sync_fifo #(
   parameter int WIDTH = 64,
   parameter int DEPTH = 4
) (
   input  logic             Clk,
   input  logic             Rst,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             push,
   input  logic             pop,
   output logic [WIDTH-1:0] rd_data,
   output logic             full,
   output logic             empty
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW:0]      count;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == (AW+1)'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign rd_data = mem[rd_ptr];

   // Pointer and occupancy bookkeeping; a simultaneous push and pop leaves the count unchanged.
   always_ff @(posedge Clk) begin
      if (Rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Sample storage; rejected pushes leave contents untouched.
   always_ff @(posedge Clk) begin
      if (do_push) mem[wr_ptr] <= wr_data;
   end

endmodule

// File: rtl/sample_uart_framer.sv
// Buffers filtered samples and streams each as SYNC, data bytes MSB-first, XOR checksum
// through a byte-wide UART TX core using a start/busy handshake.
module sample_uart_framer
   import filter_pkg::*;
#(
   parameter int         DATAWIDTH  = 64,
   parameter int         FIFO_DEPTH = 4,
   parameter logic [7:0] SYNC_BYTE  = SYNC_BYTE_DEFAULT
) (
   input  logic                        Clk,
   input  logic                        Rst,
   input  logic signed [DATAWIDTH-1:0] SampleIn,
   input  logic                        SampleValid,
   output logic                        SampleReady,
   output logic [7:0]                  tx_data,
   output logic                        tx_start,
   input  logic                        tx_busy,
   output logic                        Overflow,
   output logic [15:0]                 FramesSent
);

   localparam int NBYTES = nbytes(DATAWIDTH);
   localparam int BCW    = $clog2(NBYTES + 2);

   framer_state_t        state;
   logic [DATAWIDTH-1:0] fifo_rd;
   logic                 fifo_full;
   logic                 fifo_empty;
   logic                 fifo_pop;
   logic [DATAWIDTH-1:0] shreg;
   logic [7:0]           csum;
   logic [BCW-1:0]       byte_cnt;
   logic                 advance;
   logic                 more_data;

   sync_fifo #(
      .WIDTH (DATAWIDTH),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .Clk     (Clk),
      .Rst     (Rst),
      .wr_data (SampleIn),
      .push    (SampleValid),
      .pop     (fifo_pop),
      .rd_data (fifo_rd),
      .full    (fifo_full),
      .empty   (fifo_empty)
   );

   assign SampleReady = !fifo_full;
   assign fifo_pop    = (state == LOAD);
   assign advance     = (state == WAIT_LO) && !tx_busy;
   assign more_data   = (byte_cnt < BCW'(NBYTES));
   // The start pulse is decoded from START so the TX core samples it on the edge that leaves
   // START; it can never coincide with tx_busy and lasts exactly one cycle.
   assign tx_start    = (state == START) && !tx_busy;

   // Sticky overflow flag: a sample offered while the buffer is full is lost.
   always_ff @(posedge Clk) begin
      if (Rst) begin
         Overflow <= 1'b0;
      end else if (SampleValid && fifo_full) begin
         Overflow <= 1'b1;
      end
   end

   // Byte sequencer: walks SYNC, data bytes and checksum through the start/busy handshake.
   always_ff @(posedge Clk) begin
      if (Rst) begin
         state      <= IDLE;
         tx_data    <= 8'h00;
         byte_cnt   <= '0;
         FramesSent <= 16'h0000;
      end else begin
         case (state)
            IDLE: begin
               if (!fifo_empty) state <= LOAD;
            end
            LOAD: begin
               tx_data  <= SYNC_BYTE;
               byte_cnt <= '0;
               state    <= START;
            end
            START: begin
               if (!tx_busy) state <= WAIT_HI;
            end
            WAIT_HI: begin
               if (tx_busy) state <= WAIT_LO;
            end
            WAIT_LO: begin
               if (!tx_busy) begin
                  if (more_data) begin
                     tx_data  <= shreg[DATAWIDTH-1 -: 8];
                     byte_cnt <= byte_cnt + 1'b1;
                     state    <= START;
                  end else if (byte_cnt == BCW'(NBYTES)) begin
                     tx_data  <= csum;
                     byte_cnt <= byte_cnt + 1'b1;
                     state    <= START;
                  end else begin
                     FramesSent <= FramesSent + 16'd1;
                     state      <= fifo_empty ? IDLE : LOAD;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Sample shift register and running checksum; loaded on LOAD, advanced per data byte.
   always_ff @(posedge Clk) begin
      if (state == LOAD) begin
         shreg <= fifo_rd;
         csum  <= 8'h00;
      end else if (advance && more_data) begin
         csum  <= csum ^ shreg[DATAWIDTH-1 -: 8];
         shreg <= shreg << 8;
      end
   end

endmodule

// File: tb/tb_sample_uart_framer.sv
// Directed bench for sample_uart_framer with a simple TX core model.
module tb_sample_uart_framer;

   logic               Clk = 1'b0;
   logic               Rst = 1'b1;
   logic signed [63:0] SampleIn = '0;
   logic               SampleValid = 1'b0;
   logic               SampleReady;
   logic [7:0]         tx_data;
   logic               tx_start;
   logic               tx_busy;
   logic               Overflow;
   logic [15:0]        FramesSent;

   logic       hold_busy = 1'b0;
   int         busy_cnt = 0;
   int         cyc = 0;
   int         viol = 0;
   logic [7:0] rx_q[$];
   int         st_q[$];
   int         total = 0;
   int         bad = 0;
   int         exp_frames = 0;

   typedef struct packed {
      logic [63:0] sample;
      logic [7:0]  csum;
   } vec_t;

   vec_t vecs[6];

   sample_uart_framer dut (
      .Clk         (Clk),
      .Rst         (Rst),
      .SampleIn    (SampleIn),
      .SampleValid (SampleValid),
      .SampleReady (SampleReady),
      .tx_data     (tx_data),
      .tx_start    (tx_start),
      .tx_busy     (tx_busy),
      .Overflow    (Overflow),
      .FramesSent  (FramesSent)
   );

   always #5 Clk = ~Clk;

   assign tx_busy = hold_busy || (busy_cnt != 0);

   // TX core model: busy for 10 cycles after accepting a start; records every byte launched.
   always @(posedge Clk) begin
      cyc <= cyc + 1;
      if (Rst) busy_cnt <= 0;
      else if (tx_start && busy_cnt == 0) busy_cnt <= 10;
      else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
      if (tx_start === 1'b1) begin
         rx_q.push_back(tx_data);
         st_q.push_back(cyc);
         if (tx_busy) viol++;
      end
   end

   initial begin
      #400000;
      $display("FAIL global_timeout: got timeout want completion");
      $fatal(1, "timeout");
   end

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   task automatic drive(input logic [63:0] s, input logic v);
      @(negedge Clk);
      SampleIn    = s;
      SampleValid = v;
   endtask

   task automatic wait_frames(input int target, input string nm);
      int n;
      n = 0;
      while (FramesSent != 16'(target) && n < 3000) begin
         @(posedge Clk); #1;
         n++;
      end
      chk(nm, FramesSent, 64'(target));
   endtask

   task automatic check_frame(input logic [63:0] s, input logic [7:0] cs, input string nm);
      logic [7:0] exp_b;
      chk({nm, "_len_ok"}, 64'(rx_q.size() >= 10), 64'd1);
      if (rx_q.size() >= 10) begin
         for (int i = 0; i < 10; i++) begin
            if (i == 0)      exp_b = 8'hA5;
            else if (i == 9) exp_b = cs;
            else             exp_b = 8'((s >> (8 * (8 - i))) & 64'hFF);
            chk($sformatf("%s_b%0d", nm, i), rx_q.pop_front(), exp_b);
         end
      end else begin
         rx_q.delete();
      end
   endtask

   task automatic do_reset(input string nm);
      @(negedge Clk);
      Rst = 1'b1;
      @(posedge Clk); #1;
      chk({nm, "_tx_start"}, tx_start, 0);
      chk({nm, "_ready"}, SampleReady, 1);
      chk({nm, "_frames"}, FramesSent, 0);
      chk({nm, "_overflow"}, Overflow, 0);
      @(negedge Clk);
      Rst = 1'b0;
      rx_q.delete();
      st_q.delete();
      exp_frames = 0;
   endtask

   initial begin
      logic [63:0] t4[6];
      logic        rdy4[6];
      logic        ovf4[6];
      int          s0;
      int          intra;
      int          n;

      vecs[0] = '{64'h0123_4567_89AB_CDEF, 8'h00};
      vecs[1] = '{64'hFFFF_FFFF_FFFF_FFFF, 8'h00};
      vecs[2] = '{64'h0000_0000_0000_0000, 8'h00};
      vecs[3] = '{64'h8000_0000_0000_00FF, 8'h7F};
      vecs[4] = '{64'hDEAD_BEEF_0000_0000, 8'h22};
      vecs[5] = '{64'h1122_3344_5566_7788, 8'h88};

      t4[0] = 64'h11;
      t4[1] = 64'h2200;
      t4[2] = 64'h33_0000;
      t4[3] = 64'h4400_0000;
      t4[4] = 64'h55_0000_0000;
      t4[5] = 64'h66;

      repeat (3) @(posedge Clk);
      #1;
      chk("rst_tx_data", tx_data, 8'h00);
      do_reset("rst0");

      // Latency: push accepted at edge N, start visible after edge N+2.
      drive(64'h1, 1'b1);
      @(posedge Clk); #1;
      SampleValid = 1'b0;
      @(posedge Clk); #1;
      chk("lat_n1_start", tx_start, 0);
      @(posedge Clk); #1;
      chk("lat_n2_start", tx_start, 1);
      chk("lat_n2_data", tx_data, 8'hA5);
      @(posedge Clk); #1;
      chk("lat_n3_start", tx_start, 0);
      exp_frames++;
      wait_frames(exp_frames, "lat_frames");
      check_frame(64'h1, 8'h01, "lat");

      // Single-frame vectors.
      for (int v = 0; v < 6; v++) begin
         drive(vecs[v].sample, 1'b1);
         drive(64'h0, 1'b0);
         exp_frames++;
         wait_frames(exp_frames, $sformatf("vec%0d_frames", v));
         check_frame(vecs[v].sample, vecs[v].csum, $sformatf("vec%0d", v));
      end

      // Back-to-back frames.
      st_q.delete();
      drive(64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
      drive(64'h0, 1'b1);
      drive(64'h1, 1'b1);
      drive(64'h0, 1'b0);
      exp_frames += 3;
      wait_frames(exp_frames, "b2b_frames");
      chk("b2b_starts", st_q.size(), 30);
      if (st_q.size() == 30) begin
         intra = st_q[1] - st_q[0];
         chk("b2b_gap1", 64'((st_q[10] - st_q[9]) < 2 * intra), 1);
         chk("b2b_gap2", 64'((st_q[20] - st_q[19]) < 2 * intra), 1);
      end
      check_frame(64'hFFFF_FFFF_FFFF_FFFF, 8'h00, "b2b0");
      check_frame(64'h0, 8'h00, "b2b1");
      check_frame(64'h1, 8'h01, "b2b2");

      // Busy held high: buffer fills, overflow, start withheld.
      @(negedge Clk);
      hold_busy = 1'b1;
      s0 = st_q.size();
      for (int i = 0; i < 6; i++) begin
         @(negedge Clk);
         SampleIn    = t4[i];
         SampleValid = 1'b1;
         @(posedge Clk); #1;
         rdy4[i] = SampleReady;
         ovf4[i] = Overflow;
      end
      SampleValid = 1'b0;
      chk("ovf_ready_e4", rdy4[3], 1);
      chk("ovf_ready_e5", rdy4[4], 0);
      chk("ovf_flag_e5", ovf4[4], 0);
      chk("ovf_flag_e6", ovf4[5], 1);
      repeat (55) @(posedge Clk);
      #1;
      chk("hold_no_start", st_q.size(), 64'(s0));
      chk("hold_overflow_sticky", Overflow, 1);
      @(negedge Clk);
      hold_busy = 1'b0;
      repeat (3) @(posedge Clk);
      #1;
      chk("hold_one_start", st_q.size(), 64'(s0 + 1));
      exp_frames += 5;
      wait_frames(exp_frames, "ovf_frames");
      for (int i = 0; i < 5; i++)
         check_frame(t4[i], t4[i][8*i +: 8], $sformatf("ovf%0d", i));
      chk("ovf_dropped_gone", rx_q.size(), 0);

      // Reset during the 4th data byte.
      drive(64'h1122_3344_5566_7788, 1'b1);
      drive(64'h0, 1'b0);
      n = 0;
      while (rx_q.size() < 5 && n < 2000) begin
         @(posedge Clk); #1;
         n++;
      end
      chk("midrst_reached", 64'(rx_q.size()), 5);
      do_reset("midrst");
      repeat (15) @(posedge Clk);
      #1;
      chk("midrst_no_resume", rx_q.size(), 0);
      drive(64'hCAFE_F00D_1234_5678, 1'b1);
      drive(64'h0, 1'b0);
      exp_frames++;
      wait_frames(exp_frames, "post_rst_frames");
      check_frame(64'hCAFE_F00D_1234_5678, 8'hC1, "post_rst");

      chk("no_start_while_busy", viol, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
